// File: rtl/controle_pkg.sv
// Shared codes for the multicycle control unit: state encoding, opcodes,
// datapath mux selects and the packed control word driven by the decoder.
package controle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/controle_multiciclo_decodificador_saidas.sv
// Moore output decode: state code -> control word, purely combinational.
// Any code without an entry (including the unused 12-15) yields an all-zero word.
module decodificador_saidas
    import controle_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM: state register plus next-state logic; outputs
// are a Moore decode of the state, forced to zero while reset is held.
module controle_multiciclo
    import controle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    ctrl_t  ctrl_gated;

    always_ff @(posedge clock) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Op only matters in DECODE and MEMADR; every other state ignores it.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: next_state = S_MEMWB;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    decodificador_saidas u_dec (
        .state (state),
        .ctrl  (ctrl)
    );

    // Gate everything during reset so PC, memory and register file stay untouched.
    assign ctrl_gated = reset ? '0 : ctrl;

    assign PCWrite     = ctrl_gated.pc_write;
    assign PCWriteCond = ctrl_gated.pc_write_cond;
    assign IorD        = ctrl_gated.i_or_d;
    assign MemRead     = ctrl_gated.mem_read;
    assign MemWrite    = ctrl_gated.mem_write;
    assign IRWrite     = ctrl_gated.ir_write;
    assign MemtoReg    = ctrl_gated.mem_to_reg;
    assign RegDst      = ctrl_gated.reg_dst;
    assign RegWrite    = ctrl_gated.reg_write;
    assign ALUSrcA     = ctrl_gated.alu_src_a;
    assign ALUSrcB     = ctrl_gated.alu_src_b;
    assign ALUOp       = ctrl_gated.alu_op;
    assign PCSource    = ctrl_gated.pc_source;
    assign State       = reset ? 4'd0 : state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: instruction-path reference model checked every
// cycle, plus directed literal sequences, reset scenarios and random opcodes.
module tb_controle_multiciclo;

    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] BAD   = 6'b111111;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'd0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int vectors = 0;
    int errors  = 0;

    controle_multiciclo dut (
        .clock(clock), .reset(reset), .Op(Op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State)
    );

    always #5 clock = ~clock;

    logic [15:0] dut_word;
    assign dut_word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] pk(input bit pcw, input bit pcwc, input bit iord,
                                       input bit mr, input bit mw, input bit irw,
                                       input bit m2r, input bit rd, input bit rw,
                                       input bit asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] pcs);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
    endfunction

    // Control word each step of an instruction must present.
    function automatic logic [15:0] exp_word(input int st);
        case (st)
            0:       return pk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00);
            1:       return pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
            2, 10:   return pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
            3:       return pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
            4:       return pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
            5:       return pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
            6:       return pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
            7:       return pk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
            8:       return pk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
            9:       return pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
            11:      return pk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
            default: return 16'h0000;
        endcase
    endfunction

    // Reference model: the opcode seen in DECODE fixes the remaining path of
    // the instruction; MEMADR re-reads it to choose load or store.
    int cur = 0;
    int q[$];
    bit model_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            cur = 0;
            q.delete();
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (cur == 1) begin
                q.delete();
                if (Op == LW || Op == SW) q.push_back(2);
                else if (Op == RTYPE) begin q.push_back(6); q.push_back(7); end
                else if (Op == BEQ)   q.push_back(8);
                else if (Op == JMP)   q.push_back(9);
                else if (Op == ADDI)  begin q.push_back(10); q.push_back(11); end
            end else if (cur == 2) begin
                q.delete();
                if (Op == LW) begin q.push_back(3); q.push_back(4); end
                else q.push_back(5);
            end
            if (q.size() > 0) cur = q.pop_front();
            else              cur = (cur == 0) ? 1 : 0;
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            chk("model_state", {12'd0, State}, reset ? 16'd0 : 16'(cur));
            chk("model_ctrl", dut_word, reset ? 16'd0 : exp_word(cur));
        end
    end

    // Directed instruction: seq holds the expected state codes as nibbles, first
    // state in the most significant used nibble; ends back in FETCH.
    task automatic run_seq(input string name, input logic [5:0] op, input int n,
                           input logic [31:0] seq, input int exp_rw, input int exp_mw);
        int rw_cnt = 0;
        int mw_cnt = 0;
        Op = op;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
            end
            chk(name, {12'd0, State}, {12'd0, seq[4*(n-1-k) +: 4]});
            if (k < n - 1) begin
                rw_cnt += int'(RegWrite);
                mw_cnt += int'(MemWrite);
            end
        end
        chk({name, "_regwrite_cycles"}, 16'(rw_cnt), 16'(exp_rw));
        chk({name, "_memwrite_cycles"}, 16'(mw_cnt), 16'(exp_mw));
    endtask

    initial begin
        @(posedge clock);
        #1;
        chk("reset_state", {12'd0, State}, 16'd0);
        chk("reset_ctrl", dut_word, 16'h0000);
        reset = 1'b0;
        #1;
        chk("fetch_literal", dut_word, 16'h9410);

        run_seq("lw",    LW,    6, 32'h00012340, 1, 0);
        run_seq("sw",    SW,    5, 32'h00001250, 0, 1);
        run_seq("rtype", RTYPE, 5, 32'h00001670, 1, 0);
        run_seq("beq",   BEQ,   4, 32'h00000180, 0, 0);
        run_seq("j",     JMP,   4, 32'h00000190, 0, 0);
        run_seq("bad",   BAD,   3, 32'h00000010, 0, 0);
        run_seq("addi",  ADDI,  5, 32'h0001AB00 >> 4, 1, 0);

        // Reset in the middle of a load: no write-back may follow.
        begin
            int rw_cnt = 0;
            Op = LW;
            repeat (3) begin
                @(posedge clock);
                #1;
            end
            chk("lw_mid_state", {12'd0, State}, 16'd3);
            reset = 1'b1;
            #1;
            rw_cnt += int'(RegWrite);
            @(posedge clock);
            #1;
            chk("lw_mid_reset_state", {12'd0, State}, 16'd0);
            rw_cnt += int'(RegWrite);
            reset = 1'b0;
            Op = BAD;
            repeat (3) begin
                #1;
                rw_cnt += int'(RegWrite);
                @(posedge clock);
                #1;
            end
            chk("lw_mid_regwrite", 16'(rw_cnt), 16'd0);
        end

        // Random opcodes and sporadic resets; MEMADR only sees a load or store.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            #1;
            reset = ($urandom_range(0, 63) == 0);
            if (cur == 2) Op = ($urandom_range(0, 1) == 1) ? LW : SW;
            else begin
                case ($urandom_range(0, 7))
                    0: Op = LW;
                    1: Op = SW;
                    2: Op = RTYPE;
                    3: Op = BEQ;
                    4: Op = JMP;
                    5: Op = ADDI;
                    default: Op = 6'($urandom_range(0, 63));
                endcase
            end
        end

        // Reset held three cycles from wherever the random run left off.
        reset = 1'b1;
        #1;
        chk("hold_reset_ctrl0", dut_word, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            chk("hold_reset_state", {12'd0, State}, 16'd0);
            chk("hold_reset_ctrl", dut_word, 16'h0000);
        end
        reset = 1'b0;
        #1;
        chk("release_state", {12'd0, State}, 16'd0);
        chk("release_ctrl", dut_word, 16'h9410);
        @(posedge clock);
        #1;
        chk("release_next", {12'd0, State}, 16'd1);
        @(negedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameters: none; all opcode and state codes SHALL come from the shared package.
REQ-002 clock  in  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 Op  in  6  opcode field instr[31:26] from the instruction register; sampled in DECODE and MEMADR only.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  PC and memory controls.
REQ-006 MemtoReg, RegDst, RegWrite  out  1 each  register-file write-port controls (RegWrite drives the register file's write enable).
REQ-007 ALUSrcA  out  1;  ALUSrcB  out  2;  ALUOp  out  2;  PCSource  out  2  datapath mux and ALU controls.
REQ-008 State  out  4  current state code, for debug and verification.

Function
REQ-009 Moore FSM: outputs SHALL be a pure decode of the registered state; unlisted outputs SHALL be 0 in every state.
REQ-010 Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-011 Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.
REQ-012 FETCH->DECODE unconditionally.
REQ-013 DECODE->MEMADR on LW/SW; ->EXECUTE on RTYPE; ->BRANCH on BEQ; ->JUMP on J; ->ADDIEX on ADDI.
REQ-014 DECODE with any other opcode SHALL go to FETCH (executed as nop; no register or memory write).
REQ-015 MEMADR->MEMREAD on LW, ->MEMWRITE on SW; MEMREAD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-016 MEMWB, MEMWRITE, ALUWB, BRANCH, JUMP, ADDIWB SHALL go to FETCH.
REQ-017 Unused codes 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-018 Latency in cycles including FETCH: LW 5; SW, RTYPE, ADDI 4; BEQ, J 3.
REQ-019 FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-021 MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-022 MEMREAD: MemRead=1, IorD=1.  MEMWRITE: MemWrite=1, IorD=1.
REQ-023 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1.  ALUWB: RegWrite=1, RegDst=1, MemtoReg=0.  ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-024 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-026 JUMP: PCWrite=1, PCSource=10.
REQ-027 RegWrite SHALL be high for exactly one cycle per LW/RTYPE/ADDI and never for SW/BEQ/J/illegal.
REQ-028 Op changes outside DECODE/MEMADR SHALL have no effect.

Reset
REQ-029 With reset high at a rising edge, the state SHALL become FETCH regardless of the current state (including mid-instruction).
REQ-030 While reset is high, all outputs SHALL be 0 (gated), so PC, memory and the register file are not modified; State SHALL read 0.
REQ-031 On the first edge after reset deasserts, the FSM SHALL be in FETCH with the REQ-019 outputs active.

Structure
REQ-032 Shared package controle_pkg SHALL hold the state codes, the opcode constants and the ALUOp/ALUSrcB/PCSource code constants.
REQ-033 One sub-module, decodificador_saidas (state -> control word, combinational), SHALL be used; the next-state register and logic stay in controle_multiciclo.

Verification
REQ-034 Reset held 3 cycles from an arbitrary state -> State=0 and all outputs 0; after release, FETCH outputs per REQ-019.
REQ-035 Op=100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-036 Op=101011 -> 0,1,2,5,0 with MemWrite=1 only in state 5; Op=000000 -> 0,1,6,7,0 with RegDst=1 in state 7.
REQ-037 Op=000100 -> 0,1,8,0 with PCWriteCond=1 and PCSource=01; Op=000010 -> 0,1,9,0 with PCSource=10.
REQ-038 Op=111111 -> 0,1,0 with RegWrite and MemWrite never asserted; Op=001000 -> 0,1,10,11,0.
REQ-039 Reset asserted while in state 3 (LW) -> State=0 next edge, RegWrite never asserted for that instruction.
